// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and defaults for the instruction memory loader
//
// Purpose: loader state encoding, default geometry and the bytes-per-word helper.
// Ports:   none (package).

package im_loader_pkg;

  localparam int unsigned N_DEFAULT      = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned DEPTH_DEFAULT  = 32;

  function automatic int unsigned bytes_per_word(input int unsigned n);
    return n / 8;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(N_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/im_loader_byte_packer.sv
// rtl/im_loader_byte_packer.sv - little-endian byte-to-word packer
//
// Purpose: shifts accepted bytes into an N-bit word (first byte lands in bits 7:0),
//          counts the byte position and pulses word_ready_o for one cycle after the
//          byte that completes a word.
// Ports:   clk, rst_n      clock, synchronous active-low reset
//          clear_i         drop any partial word and restart at byte 0
//          byte_en_i       a data byte is accepted this cycle
//          byte_i          the accepted byte
//          last_byte_o     the next accepted byte completes the current word
//          word_ready_o    registered one-cycle pulse, word_o valid while high
//          word_o          packed word

module im_loader_byte_packer
  import im_loader_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         byte_en_i,
  input  logic [7:0]   byte_i,
  output logic         last_byte_o,
  output logic         word_ready_o,
  output logic [N-1:0] word_o
);

  localparam int unsigned BPW   = bytes_per_word(N);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     sreg_q;
  logic             ready_q;

  assign last_byte_o  = (idx_q == IDX_W'(BPW - 1));
  assign word_ready_o = ready_q;
  // After BPW shifts the first byte has moved down to bits 7:0; the register is
  // left untouched until the next accepted byte, so it is stable during the pulse.
  assign word_o       = sreg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      sreg_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (clear_i) begin
        idx_q  <= '0;
        sreg_q <= '0;
      end else if (byte_en_i) begin
        sreg_q <= (sreg_q >> 8) | (N'(byte_i) << (N - 8));
        if (last_byte_o) begin
          idx_q   <= '0;
          ready_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - serial program loader for the instruction memory
//
// Purpose: accepts length, payload and XOR checksum bytes, writes packed words into
//          the instruction memory and holds the CPU until a verified load.
// Ports:   clk, rst_n               clock, synchronous active-low reset
//          start                    one-cycle load request (IDLE/DONE/ERR only)
//          byte_valid, byte_data    incoming byte stream
//          byte_ready               loader accepts a byte this cycle
//          we, waddr, wdata         one-cycle instruction memory write
//          cpu_hold                 CPU held while high
//          done, error              load result levels

module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned N      = N_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              byte_ready_q, byte_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              restart;
  logic              last_byte;
  logic [7:0]        last_word;

  assign accept    = byte_valid && byte_ready_q;
  assign restart   = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  // len is in 1..DEPTH here, so len-1 always fits in ADDR_W bits.
  assign last_word = len_q - 8'd1;

  im_loader_byte_packer #(.N(N)) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (restart),
    .byte_en_i    (accept && state_q == ST_DATA),
    .byte_i       (byte_data),
    .last_byte_o  (last_byte),
    .word_ready_o (we),
    .word_o       (wdata)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    wcnt_d  = wcnt_q;
    waddr_d = waddr_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LEN;
      ST_LEN: begin
        if (accept) begin
          if (byte_data == 8'd0 || 32'(byte_data) > 32'(DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            len_d   = byte_data;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          chk_d = chk_q ^ byte_data;
          if (last_byte) begin
            // Address is captured alongside the packer's pulse so we/waddr/wdata align.
            waddr_d = wcnt_q;
            if (wcnt_q == ADDR_W'(last_word)) state_d = ST_CHK;
            else                              wcnt_d  = wcnt_q + 1'b1;
          end
        end
      end
      ST_CHK: begin
        if (accept) state_d = (byte_data == chk_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
          chk_d   = '0;
          wcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered from the next state so they track state_q exactly.
    byte_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_hold_d   = (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      chk_q        <= '0;
      wcnt_q       <= '0;
      waddr_q      <= '0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
      wcnt_q       <= wcnt_d;
      waddr_q      <= waddr_d;
      byte_ready_q <= byte_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign waddr      = waddr_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed self-checking bench for im_loader

module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];

  always #5 clk = ~clk;

  im_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always @(negedge clk) begin
    if (rst_n && we) begin
      log_addr.push_back(waddr);
      log_data.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!byte_ready) begin
      check("ready_timeout", 32'(byte_ready), 32'd1);
    end else begin
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic check_status(input string tag, input logic r, input logic h,
                              input logic d, input logic e);
    check({tag, "_ready"}, 32'(byte_ready), 32'(r));
    check({tag, "_hold"},  32'(cpu_hold),   32'(h));
    check({tag, "_done"},  32'(done),       32'(d));
    check({tag, "_error"}, 32'(error),      32'(e));
  endtask

  task automatic two_word(input logic [7:0] chk);
    pulse_start();
    check("len_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h02);
    send_word(32'h00000513, 0);
    check("w0_we", 32'(we), 32'd1);
    check("w0_addr", 32'(waddr), 32'd0);
    check("w0_data", wdata, 32'h00000513);
    send_word(32'h00100593, 0);
    check("w1_we", 32'(we), 32'd1);
    check("w1_addr", 32'(waddr), 32'd1);
    check("w1_data", wdata, 32'h00100593);
    send_byte(chk);
  endtask

  initial begin
    logic [31:0] words[32];
    logic [7:0]  x;

    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;

    // Reset with random inputs
    repeat (2) begin
      start      = 1'($urandom);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    byte_valid = 1'b0;
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check_status("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Good two-word load
    log_addr.delete();
    log_data.delete();
    two_word(8'h90);
    check_status("good", 1'b0, 1'b0, 1'b1, 1'b0);
    check("good_nwr", 32'(log_addr.size()), 32'd2);

    // Bad checksum
    two_word(8'h91);
    check_status("badchk", 1'b0, 1'b1, 1'b0, 1'b1);
    check("badchk_nwr", 32'(log_addr.size()), 32'd4);
    pulse_start();
    check_status("restart", 1'b1, 1'b1, 1'b0, 1'b0);

    // Bad lengths
    send_byte(8'h00);
    check_status("len0", 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_start();
    send_byte(8'h21);
    check_status("len33", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    check("badlen_nwr", 32'(log_addr.size()), 32'd4);

    // Full 32-word load, gapped
    log_addr.delete();
    log_data.delete();
    pulse_start();
    send_byte(8'h20);
    x = 8'h00;
    for (int i = 0; i < 32; i++) begin
      words[i] = $urandom;
      x = x ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
      send_word(words[i], 3);
    end
    repeat (3) tick();
    check("full_ready_chk", 32'(byte_ready), 32'd1);
    send_byte(x);
    repeat (3) tick();
    check_status("full", 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_nwr", 32'(log_addr.size()), 32'd32);
    for (int i = 0; i < 32 && i < log_addr.size(); i++) begin
      check($sformatf("full_addr%0d", i), 32'(log_addr[i]), 32'(i));
      check($sformatf("full_data%0d", i), log_data[i], words[i]);
    end

    // Reset in the middle of word 1
    pulse_start();
    send_byte(8'h02);
    send_word(32'h11223344, 0);
    send_byte(8'h55);
    log_addr.delete();
    log_data.delete();
    send_byte(8'h66);
    rst_n = 1'b0;
    tick();
    check("midrst_we", 32'(we), 32'd0);
    check_status("midrst", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_nwr", 32'(log_addr.size()), 32'd0);

    // Fresh one-word load after reset
    pulse_start();
    send_byte(8'h01);
    send_word(32'hDDCCBBAA, 1);
    send_byte(8'h00);
    check_status("fresh", 1'b0, 1'b0, 1'b1, 1'b0);
    check("fresh_nwr", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check("fresh_addr", 32'(log_addr[0]), 32'd0);
      check("fresh_data", log_data[0], 32'hDDCCBBAA);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
